// File: rtl/sdram_wb_cache_if.sv
// Classic Wishbone bus bundle shared by the CPU-side and SDRAM-side links of the cache.
interface sdram_wb_cache_if #(
    parameter int ADR_W = 25
);
    logic             cyc;
    logic             stb;
    logic             we;
    logic [3:0]       sel;
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat_w;   // master -> slave write data
    logic [31:0]      dat_r;   // slave -> master read data
    logic             ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/sdram_wb_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache between a CPU Wishbone
// master and an SDRAM Wishbone controller, with full invalidate and hit/miss counters.
module sdram_wb_cache #(
    parameter int LINES = 64,
    parameter int ADR_W = 25
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    sdram_wb_cache_if.slave      s,
    sdram_wb_cache_if.master     m,
    input  logic                 inv_i,
    output logic                 busy_o,
    output logic [15:0]          hit_cnt_o,
    output logic [15:0]          miss_cnt_o
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADR_W - 2 - IDX_W;

    typedef enum logic [2:0] {INVAL, IDLE, CHECK, MREAD, MWRITE} state_t;

    // Byte-lane merge of a partial write into an existing line
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic               inv_pend_q, inv_pend_d;
    logic               abort_q, abort_d;
    logic [ADR_W-3:0]   word_q, word_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic               hit_q, hit_d;
    logic               s_ack_q, s_ack_d;
    logic [31:0]        s_dat_q, s_dat_d;
    logic               m_req_q, m_req_d;
    logic               m_we_q, m_we_d;
    logic [15:0]        hit_cnt_q, hit_cnt_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;

    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [31:0]        rd_data_q;
    logic [TAG_W-1:0]   rd_tag_q;

    logic               accept;
    logic               tag_hit;
    logic               rd_en;
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic               valid_set;
    logic               valid_clr;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   rd_idx;

    assign idx_q   = word_q[IDX_W-1:0];
    assign tag_q   = word_q[ADR_W-3:IDX_W];
    assign rd_idx  = s.adr[IDX_W+1:2];
    assign accept  = s.cyc & s.stb & ~s_ack_q;
    assign tag_hit = valid_q[idx_q] & (rd_tag_q == tag_q);

    // Next-state and datapath control for the cache controller
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        sweep_d    = sweep_q;
        inv_pend_d = inv_pend_q;
        abort_d    = abort_q;
        word_d     = word_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        hit_d      = hit_q;
        s_ack_d    = 1'b0;
        s_dat_d    = s_dat_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rd_en      = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = m.dat_r;
        valid_set  = 1'b0;
        valid_clr  = 1'b0;

        // Invalidate requests arriving mid-transaction wait for the return to IDLE
        if (inv_i && state_q != IDLE && state_q != INVAL)
            inv_pend_d = 1'b1;

        case (state_q)
            INVAL: begin
                valid_clr = 1'b1;
                if (inv_i) begin
                    sweep_d = '0;
                end else if (sweep_q == IDX_W'(LINES - 1)) begin
                    sweep_d = '0;
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            IDLE: begin
                if (inv_i || inv_pend_q) begin
                    inv_pend_d = 1'b0;
                    sweep_d    = '0;
                    state_d    = INVAL;
                end else if (accept) begin
                    word_d  = s.adr[ADR_W-1:2];
                    dat_d   = s.dat_w;
                    sel_d   = s.sel;
                    we_d    = s.we;
                    abort_d = 1'b0;
                    rd_en   = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                hit_d = tag_hit;
                if (we_q) begin
                    m_req_d = 1'b1;
                    m_we_d  = 1'b1;
                    state_d = MWRITE;
                end else if (tag_hit) begin
                    s_dat_d   = rd_data_q;
                    s_ack_d   = s.cyc;
                    hit_cnt_d = hit_cnt_q + 16'd1;
                    state_d   = IDLE;
                end else begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    state_d    = MREAD;
                end
            end
            MREAD: begin
                if (!s.cyc) abort_d = 1'b1;
                if (m.ack) begin
                    m_req_d   = 1'b0;
                    mem_we    = 1'b1;
                    mem_wdata = m.dat_r;
                    valid_set = 1'b1;
                    s_dat_d   = m.dat_r;
                    s_ack_d   = ~abort_q & s.cyc;
                    state_d   = IDLE;
                end
            end
            MWRITE: begin
                if (!s.cyc) abort_d = 1'b1;
                if (m.ack) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    s_ack_d = ~abort_q & s.cyc;
                    if (hit_q) begin
                        mem_we    = 1'b1;
                        mem_wdata = merge_bytes(rd_data_q, dat_q, sel_q);
                    end else if (sel_q == 4'hF) begin
                        mem_we    = 1'b1;
                        mem_wdata = dat_q;
                        valid_set = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = INVAL;
        endcase
    end

    // Controller state and registered bus outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= INVAL;
            sweep_q    <= '0;
            inv_pend_q <= 1'b0;
            abort_q    <= 1'b0;
            word_q     <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            s_ack_q    <= 1'b0;
            s_dat_q    <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            inv_pend_q <= inv_pend_d;
            abort_q    <= abort_d;
            word_q     <= word_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            s_ack_q    <= s_ack_d;
            s_dat_q    <= s_dat_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Line storage: synchronous read at request acceptance, write on fill or merge
    // NOTE: the arrays have no reset so they map onto block RAM; validity lives in valid_q.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            data_mem[idx_q] <= mem_wdata;
            tag_mem[idx_q]  <= tag_q;
        end
        if (rd_en) begin
            rd_data_q <= data_mem[rd_idx];
            rd_tag_q  <= tag_mem[rd_idx];
        end
    end

    // Valid bits: cleared only by the invalidate sweep, set by fills and allocating writes
    always_ff @(posedge wb_clk_i) begin
        if (valid_clr)
            valid_q[sweep_q] <= 1'b0;
        else if (valid_set)
            valid_q[idx_q] <= 1'b1;
    end

    assign s.ack      = s_ack_q;
    assign s.dat_r    = s_dat_q;
    assign m.cyc      = m_req_q;
    assign m.stb      = m_req_q;
    assign m.we       = m_we_q;
    assign m.sel      = m_we_q ? sel_q : 4'hF;
    assign m.adr      = {word_q, 2'b00};
    assign m.dat_w    = dat_q;
    assign busy_o     = (state_q == INVAL);
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_sdram_wb_cache.sv
// Directed testbench for sdram_wb_cache: table of CPU accesses plus hand-written
// sequences for the reset sweep and the aborted-miss-with-invalidate case.
module tb_sdram_wb_cache;
    logic        clk;
    logic        rst_n;
    logic        inv;
    logic        busy;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    sdram_wb_cache_if #(.ADR_W(25)) s_bus ();
    sdram_wb_cache_if #(.ADR_W(25)) m_bus ();

    sdram_wb_cache #(.LINES(64), .ADR_W(25)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .s          (s_bus),
        .m          (m_bus),
        .inv_i      (inv),
        .busy_o     (busy),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SDRAM model: word memory, acks a request on its second observed cycle
    logic [31:0] smem [1024];
    int          sd_wait = 0;
    int          m_cnt = 0;
    int          stb_after_ack = 0;
    int          s_ack_cnt = 0;
    logic [24:0] m_last_adr;
    logic        m_last_we;
    logic [3:0]  m_last_sel;

    always @(negedge clk) begin
        if (s_bus.ack) s_ack_cnt++;
        if (m_bus.ack) begin
            m_bus.ack = 1'b0;
            if (m_bus.stb) stb_after_ack++;
            sd_wait = 0;
        end else if (m_bus.cyc && m_bus.stb) begin
            sd_wait++;
            if (sd_wait == 2) begin
                m_cnt++;
                m_last_adr = m_bus.adr;
                m_last_we  = m_bus.we;
                m_last_sel = m_bus.sel;
                if (m_bus.we) begin
                    for (int b = 0; b < 4; b++)
                        if (m_bus.sel[b])
                            smem[m_bus.adr[11:2]][8*b +: 8] = m_bus.dat_w[8*b +: 8];
                end else begin
                    m_bus.dat_r = smem[m_bus.adr[11:2]];
                end
                m_bus.ack = 1'b1;
            end
        end
    end

    // One CPU access; called right after a negedge, returns at a negedge
    task automatic access(input logic we, input logic [3:0] sel, input logic [24:0] adr,
                          input logic [31:0] dat, output logic [31:0] rdata,
                          output int lat, output bit ok);
        s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.we = we;
        s_bus.sel = sel;  s_bus.adr = adr;  s_bus.dat_w = dat;
        lat = 0; ok = 1'b0; rdata = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (s_bus.ack) begin
                ok = 1'b1;
                rdata = s_bus.dat_r;
                break;
            end
        end
        s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [24:0] adr;
        logic [31:0] dat;
        bit          exp_m;
        logic [3:0]  exp_msel;
        logic [31:0] exp_rd;
        logic [15:0] exp_hit;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          ok;
        int          m0;
        int          busy_cnt;
        int          a0;

        for (int i = 0; i < 1024; i++) smem[i] = 32'h0;
        smem[10'h040] = 32'hDEADBEEF;   // 0x000100
        smem[10'h080] = 32'hA5A50200;   // 0x000200
        smem[10'h0C0] = 32'h0BAD0300;   // 0x000300
        smem[10'h0C1] = 32'h55550304;   // 0x000304

        //          we    sel    adr        dat           m     msel   rdata         hit    miss
        vecs[0] = '{1'b0, 4'hF, 25'h000100, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 16'd1, 16'd1};
        vecs[1] = '{1'b1, 4'h3, 25'h000100, 32'h0000CAFE, 1'b1, 4'h3, 32'h0,        16'd1, 16'd1};
        vecs[2] = '{1'b0, 4'hF, 25'h000100, 32'h0,        1'b0, 4'hF, 32'hDEADCAFE, 16'd2, 16'd1};
        vecs[3] = '{1'b0, 4'hF, 25'h000200, 32'h0,        1'b1, 4'hF, 32'hA5A50200, 16'd2, 16'd2};
        vecs[4] = '{1'b0, 4'hF, 25'h000100, 32'h0,        1'b1, 4'hF, 32'hDEADCAFE, 16'd2, 16'd3};
        vecs[5] = '{1'b1, 4'hF, 25'h000300, 32'h12345678, 1'b1, 4'hF, 32'h0,        16'd2, 16'd3};
        vecs[6] = '{1'b0, 4'hF, 25'h000300, 32'h0,        1'b0, 4'hF, 32'h12345678, 16'd3, 16'd3};
        vecs[7] = '{1'b1, 4'h1, 25'h000304, 32'h000000AB, 1'b1, 4'h1, 32'h0,        16'd3, 16'd3};
        vecs[8] = '{1'b0, 4'hF, 25'h000304, 32'h0,        1'b1, 4'hF, 32'h555503AB, 16'd3, 16'd4};

        s_bus.cyc = 0; s_bus.stb = 0; s_bus.we = 0; s_bus.sel = 0;
        s_bus.adr = 0; s_bus.dat_w = 0;
        m_bus.ack = 0; m_bus.dat_r = 0;
        inv = 0; rst_n = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'b0, busy}, 32'd1);
        check("rst_s_ack", {31'b0, s_bus.ack}, 32'd0);
        check("rst_s_dat", s_bus.dat_r, 32'h0);
        check("rst_m_cyc", {31'b0, m_bus.cyc}, 32'd0);
        check("rst_m_stb", {31'b0, m_bus.stb}, 32'd0);
        check("rst_hit",   {16'b0, hit_cnt}, 32'd0);
        check("rst_miss",  {16'b0, miss_cnt}, 32'd0);

        // Sweep after reset with a read pending; the read waits for the sweep to end
        rst_n = 1'b1;
        s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.we = 1'b0;
        s_bus.sel = 4'hF; s_bus.adr = 25'h000100;
        busy_cnt = 0; ok = 1'b0; rd = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            if (s_bus.ack) begin ok = 1'b1; rd = s_bus.dat_r; end
        end
        s_bus.cyc = 1'b0; s_bus.stb = 1'b0;
        check("t1_ack_seen", {31'b0, ok}, 32'd1);
        check("t1_busy_cycles", busy_cnt, 32'd64);
        check("t1_rdata", rd, 32'hDEADBEEF);
        check("t1_m_count", m_cnt, 32'd1);
        check("t1_m_adr", {7'b0, m_last_adr}, 32'h000100);
        check("t1_m_sel", {28'b0, m_last_sel}, 32'hF);
        check("t1_m_we", {31'b0, m_last_we}, 32'd0);
        check("t1_miss", {16'b0, miss_cnt}, 32'd1);

        // Table of accesses
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            m0 = m_cnt;
            access(vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].dat, rd, lat, ok);
            check($sformatf("v%0d_ack", v), {31'b0, ok}, 32'd1);
            check($sformatf("v%0d_m_cycles", v), m_cnt - m0, vecs[v].exp_m ? 32'd1 : 32'd0);
            if (vecs[v].exp_m) begin
                check($sformatf("v%0d_m_adr", v), {7'b0, m_last_adr}, {7'b0, vecs[v].adr});
                check($sformatf("v%0d_m_we", v), {31'b0, m_last_we}, {31'b0, vecs[v].we});
                check($sformatf("v%0d_m_sel", v), {28'b0, m_last_sel}, {28'b0, vecs[v].exp_msel});
            end else begin
                check($sformatf("v%0d_hit_latency", v), lat, 32'd2);
            end
            if (!vecs[v].we)
                check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
            check($sformatf("v%0d_hit_cnt", v), {16'b0, hit_cnt}, {16'b0, vecs[v].exp_hit});
            check($sformatf("v%0d_miss_cnt", v), {16'b0, miss_cnt}, {16'b0, vecs[v].exp_miss});
        end

        // Invalidate during a read miss while the CPU abandons its cycle
        @(negedge clk);
        m0 = m_cnt;
        a0 = s_ack_cnt;
        s_bus.cyc = 1'b1; s_bus.stb = 1'b1; s_bus.we = 1'b0;
        s_bus.sel = 4'hF; s_bus.adr = 25'h000200;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_bus.cyc) ok = 1'b1;
        end
        check("t6_m_started", {31'b0, ok}, 32'd1);
        inv = 1'b1;
        s_bus.cyc = 1'b0; s_bus.stb = 1'b0;
        @(negedge clk);
        inv = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (busy) ok = 1'b1;
            else @(negedge clk);
        end
        check("t6_busy_rises", {31'b0, ok}, 32'd1);
        check("t6_m_completed", m_cnt - m0, 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("t6_busy_cycles", busy_cnt, 32'd64);
        check("t6_no_s_ack", s_ack_cnt - a0, 32'd0);
        check("t6_miss_cnt", {16'b0, miss_cnt}, 32'd5);

        m0 = m_cnt;
        access(1'b0, 4'hF, 25'h000300, 32'h0, rd, lat, ok);
        check("t6_reread_ack", {31'b0, ok}, 32'd1);
        check("t6_reread_m_cycles", m_cnt - m0, 32'd1);
        check("t6_reread_rdata", rd, 32'h12345678);
        check("t6_reread_miss", {16'b0, miss_cnt}, 32'd6);
        check("t6_reread_hit", {16'b0, hit_cnt}, 32'd3);

        @(negedge clk);
        check("stb_after_ack", stb_after_ack, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
